// File: rtl/ex_mdu_pkg.sv
// ============================================================================
// Module : ex_mdu_pkg
// Shared op codes, FSM states and sign helpers for the execute-stage MDU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_mdu_pkg;

    localparam int          REG_BUS   = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op1_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mdu_div_core.sv
// ============================================================================
// Module : mdu_div_core
// One combinational restoring radix-2 division step on a {remainder,quotient}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mdu_div_core #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_rq,
    input  logic [XLEN-1:0]   i_divisor,
    output logic [2*XLEN-1:0] o_rq
);

    // Partial remainder keeps XLEN+1 bits: the shifted-in bit can exceed XLEN.
    logic [XLEN:0]   w_part;
    logic [XLEN+1:0] w_diff;
    logic [XLEN-1:0] w_qshift;

    assign w_part   = i_rq[2*XLEN-1:XLEN-1];
    assign w_diff   = {1'b0, w_part} - {2'b00, i_divisor};
    assign w_qshift = {i_rq[XLEN-2:0], 1'b0};

    always_comb begin
        if (w_diff[XLEN+1]) begin
            o_rq = {w_part[XLEN-1:0], w_qshift};
        end else begin
            o_rq = {w_diff[XLEN-1:0], w_qshift[XLEN-1:1], 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mdu.sv
// ============================================================================
// Module : ex_mdu
// Iterative RV32M multiply/divide unit with pipeline stall request.
// Optional single-cycle multiply when MDU_FAST_MUL_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = REG_BUS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] s_op1,
    input  logic [XLEN-1:0] s_op2,
    input  logic            flush,
    input  logic            stall_hold,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      r_state, w_next;
    logic [5:0]      r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_b;
    logic            r_neg_q, r_neg_r;
    logic [2*XLEN-1:0] r_acc;

    logic            w_s1, w_s2, w_div_zero, w_ovf, w_special, w_fast;
    logic [XLEN-1:0] w_abs1, w_abs2, w_special_res, w_fast_res, w_fix_res;
    logic [XLEN:0]   w_msum;
    logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_neg;

    assign w_s1   = op1_signed(mdu_op) & s_op1[XLEN-1];
    assign w_s2   = op2_signed(mdu_op) & s_op2[XLEN-1];
    assign w_abs1 = w_s1 ? -s_op1 : s_op1;
    assign w_abs2 = w_s2 ? -s_op2 : s_op2;

    assign w_div_zero    = mdu_op[2] & (s_op2 == '0);
    assign w_ovf         = ((mdu_op == MDU_DIV) || (mdu_op == MDU_REM)) &&
                           (s_op1 == c_MIN) && (s_op2 == '1);
    assign w_special     = w_div_zero | w_ovf;
    // funct3 bit 1 distinguishes REM* from DIV* among divide ops
    assign w_special_res = w_div_zero ? (mdu_op[1] ? s_op1 : '1)
                                      : (mdu_op[1] ? '0 : c_MIN);

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     w_m1, w_m2;
    logic signed [2*XLEN+1:0] w_fprod;
    assign w_m1       = {w_s1, s_op1};
    assign w_m2       = {w_s2, s_op2};
    assign w_fprod    = w_m1 * w_m2;
    assign w_fast     = ~mdu_op[2];
    assign w_fast_res = (mdu_op == MDU_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};

    mdu_div_core #(.XLEN(XLEN)) u_div_core (
        .i_rq      (r_acc),
        .i_divisor (r_b),
        .o_rq      (w_div_next)
    );

    assign w_prod_neg = r_neg_q ? -r_acc : r_acc;

    always_comb begin
        w_fix_res = r_acc[XLEN-1:0];
        case (r_op)
            MDU_MUL:               w_fix_res = r_acc[XLEN-1:0];
            MDU_MULH, MDU_MULHSU:  w_fix_res = w_prod_neg[2*XLEN-1:XLEN];
            MDU_MULHU:             w_fix_res = r_acc[2*XLEN-1:XLEN];
            MDU_DIV:               w_fix_res = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            MDU_DIVU:              w_fix_res = r_acc[XLEN-1:0];
            MDU_REM:               w_fix_res = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            default:               w_fix_res = r_acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        stall_req = 1'b0;
        done      = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    w_next    = (w_special || w_fast) ? MDU_DONE : MDU_CALC;
                end
            end
            MDU_CALC: begin
                stall_req = 1'b1;
                if (r_cnt == 6'd31) begin
                    w_next = MDU_FIX;
                end
            end
            MDU_FIX: begin
                stall_req = 1'b1;
                w_next    = MDU_DONE;
            end
            default: begin
                done = 1'b1;
                if (!stall_hold) begin
                    w_next = MDU_IDLE;
                end
            end
        endcase
        if (flush) begin
            w_next = MDU_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            result  <= ZERO_WORD;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (start && !flush) begin
                        r_op    <= mdu_op;
                        r_b     <= w_abs2;
                        r_neg_q <= w_s1 ^ w_s2;
                        r_neg_r <= w_s1;
                        r_cnt   <= '0;
                        r_acc   <= {{XLEN{1'b0}}, w_abs1};
                        if (w_special) begin
                            result <= w_special_res;
                        end else if (w_fast) begin
                            result <= w_fast_res;
                        end
                    end
                end
                MDU_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                end
                MDU_FIX: begin
                    if (!flush) begin
                        result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit for the execute stage: it implements the RV32M instructions MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It consumes the operands and operation that the ID/EX pipeline register presents to EX, and returns one 32-bit result. While an operation is in flight it holds the pipeline with a stall request.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  EX holds a valid M-extension instruction; sampled only in IDLE.
- mdu_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- s_op1  in  XLEN  rs1 value.
- s_op2  in  XLEN  rs2 value.
- flush  in  1  synchronous abort of the current operation.
- stall_hold  in  1  another stage stalls the pipeline; holds the result in DONE.
- stall_req  out  1  freeze-pipeline request to the stall controller.
- done  out  1  result valid.
- result  out  XLEN  operation result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, no special case: latch the operands and op. Latch the absolute values of signed operands and record the result sign. Clear the 6-bit counter and go to CALC.
- IDLE, start=1, special case: compute the result directly and go to DONE. Special cases:
  - Divisor 0: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU result is the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- CALC, divide: one restoring radix-2 step per cycle on a 64-bit remainder/quotient register. Leave CALC after 32 steps (count 31 → FIX).
- CALC, multiply: one shift-add step per cycle into a 64-bit product. Leave CALC after 32 steps.
- FIX, sign correction:
  - DIV/REM: negate the quotient if operand signs differ; the remainder takes the dividend's sign.
  - MULH/MULHSU: negate the 64-bit product if the result sign is negative.
- FIX, result selection: MUL takes product[31:0]; MULH* take product[63:32]. Go to DONE.
- DONE: done=1 and result valid. If stall_hold=1, stay in DONE and keep result stable; otherwise go to IDLE next edge.
- stall_req = (IDLE & start & ~flush) | CALC | FIX. It is low in DONE, so the pipeline advances on the DONE edge.
- flush=1 in any state: go to IDLE next edge; done is not asserted for the aborted op. Flush has priority over start.
- result keeps its last value outside DONE; done=0 outside DONE.
- Reset values: state IDLE, result 0, done 0, stall_req 0, counter 0, internal registers 0.
- Reset during any state aborts immediately; no partial result is ever signalled.

## Timing
- Cycle 0 is the IDLE cycle with start=1.
- Iterative divide or multiply: CALC in cycles 1–32, FIX in cycle 33, DONE in cycle 34. stall_req is high in cycles 0–33.
- Special cases and fast multiply: DONE in cycle 1; stall_req is high in cycle 0 only.
- Back-to-back ops: a new start is accepted in the IDLE cycle directly after DONE, with no idle gap beyond that.
- start and mdu_op changes while busy are ignored; the operation uses the values latched at acceptance.

## Configuration
- MDU_FAST_MUL_EN defined:
  - All four multiply ops compute a combinational 64-bit signed/unsigned product in IDLE and go straight to DONE, with result latched there (latency 1).
  - Division is unchanged.
- MDU_FAST_MUL_EN undefined: multiply uses the 32-cycle shift-add path (latency 34); no hardware multiplier is inferred.

## Structure
- defines.v holds:
  - the `MDU_*` funct3 op codes;
  - the state encodings `MDU_IDLE`, `MDU_CALC`, `MDU_FIX` and `MDU_DONE`;
  - the existing `RegBus` and `ZeroWord`.
- Sub-module mdu_div_core holds one restoring division step: remainder/quotient in, next remainder/quotient out. It is combinational and instantiated once inside ex_mdu.
- The counter, FSM, sign fix-up and multiply path stay in ex_mdu.

## Test plan
- DIV s_op1=0xFFFFFFF9 (−7), s_op2=2 → result 0xFFFFFFFD in cycle 34. REM with the same operands → 0xFFFFFFFF. stall_req high exactly cycles 0–33.
- DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0. All four: done in cycle 1.
- Multiply ops:
  - MUL 7×0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
  - Latency is 34 without MDU_FAST_MUL_EN and 1 with it.
- flush in cycle 10 of a DIV → no done; stall_req low next cycle. A following MULHU start is accepted and returns the correct value.
- stall_hold=1 for 3 cycles in DONE → done and result stable for 4 cycles, then IDLE.
- rst asserted in cycle 20 of a DIVU → state IDLE immediately and result 0. A start after release completes with the correct value.
